// File: rtl/mem_access.sv
// Memory-access / write-back stage: runs the data-RAM handshake for LOAD/STORE and
// forwards ALU results to register-file write-back. All outputs come straight from flops.
module mem_access #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAM_WIDTH = 9,
    parameter int unsigned OP_WIDTH  = 4,
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 res_ni,
    input  logic                 valid_i,
    input  logic [OP_WIDTH-1:0]  op_i,
    input  logic [REG_AW-1:0]    dst_i,
    input  logic [WIDTH-1:0]     alu_o_i,
    input  logic [RAM_WIDTH-1:0] alu_a_i,
    output logic [RAM_WIDTH-1:0] ram_addr_o,
    output logic [WIDTH-1:0]     ram_wdata_o,
    output logic                 ram_re_o,
    output logic                 ram_we_o,
    input  logic [WIDTH-1:0]     ram_rdata_i,
    input  logic                 ram_ack_i,
    output logic                 wb_en_o,
    output logic [REG_AW-1:0]    wb_addr_o,
    output logic [WIDTH-1:0]     wb_data_o,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic                 err_clr_i
);

    // Shared opcode encoding used by the ALU stage.
    localparam logic [OP_WIDTH-1:0] OpAdd   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OpSub   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OpAnd   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OpOr    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OpXor   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OpLoadi = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OpLoad  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OpStore = OP_WIDTH'(8);

    // Last wait cycle index: the request is held for exactly TIMEOUT cycles.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

    state_e               state_q, state_d;
    logic [RAM_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 re_q, re_d;
    logic                 we_q, we_d;
    logic                 wb_en_q, wb_en_d;
    logic [REG_AW-1:0]    wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [REG_AW-1:0]    dst_q, dst_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 busy_q;
    logic                 err_q, err_d;
    logic                 err_set;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        we_d      = we_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    case (op_i)
                        OpLoad: begin
                            re_d    = 1'b1;
                            addr_d  = alu_a_i;
                            dst_d   = dst_i;
                            cnt_d   = 8'd0;
                            state_d = StRdWait;
                        end
                        OpStore: begin
                            we_d    = 1'b1;
                            addr_d  = alu_a_i;
                            wdata_d = alu_o_i;
                            cnt_d   = 8'd0;
                            state_d = StWrWait;
                        end
                        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpLoadi: begin
                            wb_en_d   = 1'b1;
                            wb_addr_d = dst_i;
                            wb_data_d = alu_o_i;
                        end
                        default: ;
                    endcase
                end
            end
            StRdWait: begin
                err_set = valid_i;
                if (ram_ack_i) begin
                    re_d      = 1'b0;
                    wb_en_d   = 1'b1;
                    wb_addr_d = dst_q;
                    wb_data_d = ram_rdata_i;
                    state_d   = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    re_d    = 1'b0;
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWrWait: begin
                err_set = valid_i;
                if (ram_ack_i) begin
                    we_d    = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    we_d    = 1'b0;
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set beats clear when both happen in the same cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            dst_q     <= '0;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d != StIdle);
            err_q     <= err_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_re_o    = re_q;
    assign ram_we_o    = we_q;
    assign wb_en_o     = wb_en_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: write-backs are checked against a scoreboard queue, RAM-side
// signals and flags are checked directly after each clock edge.
module tb_mem_access;

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpAdd   = 4'd1;
    localparam logic [3:0] OpSub   = 4'd2;
    localparam logic [3:0] OpAnd   = 4'd3;
    localparam logic [3:0] OpXor   = 4'd5;
    localparam logic [3:0] OpLoadi = 4'd6;
    localparam logic [3:0] OpLoad  = 4'd7;
    localparam logic [3:0] OpStore = 4'd8;

    logic        clk = 1'b0;
    logic        res_n;
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [15:0] alu_o;
    logic [8:0]  alu_a;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;
    logic        err;
    logic        err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] wbq[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk_i       (clk),
        .res_ni      (res_n),
        .valid_i     (valid),
        .op_i        (op),
        .dst_i       (dst),
        .alu_o_i     (alu_o),
        .alu_a_i     (alu_a),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_re_o    (ram_re),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata),
        .ram_ack_i   (ram_ack),
        .wb_en_o     (wb_en),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_data),
        .busy_o      (busy),
        .err_o       (err),
        .err_clr_i   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [15:0] data,
                         input logic [8:0] addr);
        valid = 1'b1;
        op    = o;
        dst   = d;
        alu_o = data;
        alu_a = addr;
        tick();
        valid = 1'b0;
    endtask

    // Write-back monitor: every wb_en pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (res_n && wb_en) begin
            if (wbq.size() == 0) begin
                check("wb_unexpected", 32'(wb_en), 32'd0);
            end else begin
                logic [18:0] e;
                e = wbq.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(e[18:16]));
                check("wb_data", 32'(wb_data), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        res_n = 1'b0; valid = 1'b0; op = OpNop; dst = '0; alu_o = '0; alu_a = '0;
        ram_rdata = '0; ram_ack = 1'b0; err_clr = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_re", 32'(ram_re), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        repeat (3) tick();
        res_n = 1'b1;
        tick();

        // Arithmetic write-back, then back-to-back.
        wbq.push_back({3'd3, 16'h1234});
        issue(OpAdd, 3'd3, 16'h1234, 9'h000);
        check("add_busy", 32'(busy), 32'd0);
        tick();
        check("add_wb_one_cycle", 32'(wb_en), 32'd0);
        wbq.push_back({3'd2, 16'hA5A5});
        wbq.push_back({3'd4, 16'h0F0F});
        valid = 1'b1; op = OpSub; dst = 3'd2; alu_o = 16'hA5A5;
        tick();
        op = OpAnd; dst = 3'd4; alu_o = 16'h0F0F;
        tick();
        valid = 1'b0;
        tick();

        // NOP and a stray ack while idle do nothing.
        issue(OpNop, 3'd7, 16'hFFFF, 9'h1FF);
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_re", 32'(ram_re), 32'd0);
        ram_ack = 1'b1; ram_rdata = 16'hDEAD;
        tick();
        ram_ack = 1'b0;
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_err", 32'(err), 32'd0);

        // LOAD with ack 3 cycles after ram_re rises.
        issue(OpLoad, 3'd5, 16'h0000, 9'h1A0);
        for (int i = 0; i < 2; i++) begin
            check("ld_re", 32'(ram_re), 32'd1);
            check("ld_addr", 32'(ram_addr), 32'h1A0);
            check("ld_busy", 32'(busy), 32'd1);
            tick();
        end
        check("ld_addr_ack", 32'(ram_addr), 32'h1A0);
        ram_ack = 1'b1; ram_rdata = 16'hBEEF;
        wbq.push_back({3'd5, 16'hBEEF});
        tick();
        ram_ack = 1'b0; ram_rdata = 16'h0000;
        check("ld_re_drop", 32'(ram_re), 32'd0);
        check("ld_busy_drop", 32'(busy), 32'd0);
        tick();

        // STORE acked in its second cycle.
        issue(OpStore, 3'd0, 16'h00AA, 9'h0FF);
        check("st_we1", 32'(ram_we), 32'd1);
        check("st_addr", 32'(ram_addr), 32'h0FF);
        check("st_data", 32'(ram_wdata), 32'h00AA);
        check("st_wb_en", 32'(wb_en), 32'd0);
        tick();
        check("st_we2", 32'(ram_we), 32'd1);
        check("st_data2", 32'(ram_wdata), 32'h00AA);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        check("st_we_drop", 32'(ram_we), 32'd0);
        check("st_busy", 32'(busy), 32'd0);
        tick();

        // LOAD timeout: no ack ever.
        issue(OpLoad, 3'd2, 16'h0000, 9'h055);
        cyc = 0;
        while (ram_re && cyc < 40) begin
            cyc++;
            tick();
        end
        check("to_re_cycles", 32'(cyc), 32'd15);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", 32'(err), 32'd0);

        // Valid during RD_WAIT is dropped; set beats a simultaneous clear.
        issue(OpLoad, 3'd6, 16'h0000, 9'h001);
        err_clr = 1'b1;
        issue(OpXor, 3'd7, 16'hFFFF, 9'h000);
        err_clr = 1'b0;
        check("busy_valid_err", 32'(err), 32'd1);
        check("busy_valid_re", 32'(ram_re), 32'd1);
        ram_ack = 1'b1; ram_rdata = 16'h5A5A;
        wbq.push_back({3'd6, 16'h5A5A});
        tick();
        ram_ack = 1'b0;
        check("pend_ld_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("pend_err_clr", 32'(err), 32'd0);

        // Asynchronous reset in the middle of WR_WAIT.
        issue(OpStore, 3'd0, 16'h1111, 9'h022);
        check("rst_mid_we", 32'(ram_we), 32'd1);
        #2;
        res_n = 1'b0;
        #1;
        check("rst_mid_we_drop", 32'(ram_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wb_en", 32'(wb_en), 32'd0);
        tick();
        res_n = 1'b1;
        tick();
        wbq.push_back({3'd1, 16'h0007});
        issue(OpLoadi, 3'd1, 16'h0007, 9'h000);
        check("loadi_wb_en", 32'(wb_en), 32'd1);
        repeat (3) tick();

        check("wbq_empty", 32'(wbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access/write-back stage directly downstream of the ALU. It consumes the registered ALU result, RAM address and opcode, and performs one of three actions. For LOAD/STORE it runs the data-RAM handshake. For arithmetic/LOADI it forwards the result to register-file write-back. NOP/unknown opcodes produce no side effects. It stalls upstream via busy while a RAM transaction is outstanding.

Parameters:
WIDTH, 16, datapath width (matches shared `WIDTH`)
RAM_WIDTH, 9, data-RAM address width
OP_WIDTH, 4, opcode width (opcode values are the shared OP_* constants)
REG_AW, 3, register-file index width
TIMEOUT, 15, max cycles to wait for ram_ack before aborting (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
res  in  1  asynchronous active-low reset
valid  in  1  alu_o/alu_a/op/dst hold a new instruction this cycle (one-cycle strobe)
op  in  OP_WIDTH  opcode of that instruction
dst  in  REG_AW  destination register index
alu_o  in  WIDTH  ALU result (store data for STORE; ignored for LOAD)
alu_a  in  RAM_WIDTH  ALU-computed RAM address
ram_addr  out  RAM_WIDTH  RAM address
ram_wdata  out  WIDTH  RAM write data
ram_re  out  1  RAM read request
ram_we  out  1  RAM write request
ram_rdata  in  WIDTH  RAM read data, valid when ram_ack=1 during a read
ram_ack  in  1  RAM completion, one cycle per request
wb_en  out  1  register-file write strobe (one cycle)
wb_addr  out  REG_AW  register-file write index
wb_data  out  WIDTH  register-file write data
busy  out  1  stage cannot accept valid
err  out  1  sticky error flag
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (res=0, asynchronous): state IDLE; all outputs 0; timeout counter 0; latched dst 0.
- All outputs are registered.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE with valid=1, by op:
  - OP_LOAD: next cycle ram_re=1, ram_addr=alu_a, latch dst, counter=0; go to RD_WAIT.
  - OP_STORE: next cycle ram_we=1, ram_addr=alu_a, ram_wdata=alu_o; go to WR_WAIT.
  - OP_ADD/SUB/AND/OR/XOR/LOADI: next cycle wb_en=1, wb_addr=dst, wb_data=alu_o; stay IDLE. Back-to-back valid gives one wb per cycle.
  - Any other op: no action.
- RD_WAIT:
  - ram_re and ram_addr held stable; counter increments each cycle ram_ack=0.
  - On ram_ack=1: next cycle ram_re=0, wb_en=1, wb_addr=latched dst, wb_data=ram_rdata sampled in the ack cycle; go to IDLE.
- WR_WAIT:
  - ram_we, ram_addr and ram_wdata held stable.
  - On ram_ack=1: next cycle ram_we=0; go to IDLE; no write-back.
- Latency:
  - Arithmetic: valid at cycle N -> wb_en at N+1.
  - Memory: valid at N -> request visible N+1; earliest ack N+1 -> LOAD wb_en at N+2, busy low at N+2.
- Timeout: if the counter reaches TIMEOUT with no ack, next cycle drop ram_re/ram_we, set err=1, go to IDLE, no write-back. An ack in the same cycle the counter reaches TIMEOUT counts as success.
- busy = (state != IDLE). valid=1 while busy is ignored and sets err=1.
- ram_ack while in IDLE is ignored.
- err is sticky until err_clr=1 (clears next edge). If set and clear conditions coincide, set wins.
- wb_en is never 1 in the same cycle as ram_re or ram_we rising.
- Reset mid-transaction aborts immediately: request lines drop asynchronously, no write-back, state IDLE.
- Address and data are passed unmodified, with no wrap or width arithmetic. Upper bits of alu_o beyond WIDTH do not exist.

Test Plan:
1. Reset, then valid op=OP_ADD dst=3 alu_o=16'h1234 at cycle 5 -> wb_en=1, wb_addr=3, wb_data=16'h1234 at cycle 6 only; busy stays 0.
2. valid op=OP_LOAD dst=5 alu_a=9'h1A0; RAM acks 3 cycles after ram_re rises with rdata=16'hBEEF -> ram_addr=9'h1A0 held throughout, busy=1, one wb_en with wb_addr=5, wb_data=16'hBEEF the cycle after ack; ram_re=0 then.
3. valid op=OP_STORE alu_a=9'h0FF alu_o=16'h00AA; ack after 1 cycle -> ram_we=1 for exactly 2 cycles with addr 9'h0FF, data 16'h00AA; no wb_en; busy returns 0.
4. LOAD with ram_ack never asserted, TIMEOUT=15 -> ram_re drops after 15 wait cycles, err=1, no wb_en; err_clr=1 one cycle -> err=0.
5. valid OP_XOR asserted while in RD_WAIT -> instruction dropped, err=1, no extra wb_en; the pending load completes normally.
6. Drive res=0 mid-WR_WAIT -> ram_we, busy and wb_en go 0 immediately; after release, an OP_LOADI with alu_o=16'h0007 dst=1 writes back normally.
